// File: rtl/subtractor_four_bit_serial.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - bin, one bit per clock,
// with valid/ready handshakes on both the operand and result sides.
module subtractor_four_bit_serial #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sa, sb, work;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             d, borrow_next, last, take;

  always_comb begin
    d           = sa[0] ^ sb[0] ^ borrow;
    borrow_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow);
    last        = (cnt == CW'(WIDTH - 1));
    take        = in_valid & in_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = SHIFT;
      end
      SHIFT: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The final bit is merged directly into diff so the result lands on the
  // same edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      work   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
    end else if (take) begin
      sa     <= a;
      sb     <= b;
      borrow <= bin;
      cnt    <= '0;
    end else if (state == SHIFT) begin
      sa     <= {1'b0, sa[WIDTH-1:1]};
      sb     <= {1'b0, sb[WIDTH-1:1]};
      work   <= {d, work[WIDTH-1:1]};
      borrow <= borrow_next;
      cnt    <= cnt + 1'b1;
      if (last) begin
        diff <= {d, work[WIDTH-1:1]};
        bout <= borrow_next;
      end
    end
  end

endmodule

// File: tb/tb_subtractor_four_bit_serial.sv
// Directed bench for subtractor_four_bit_serial at WIDTH=4 and WIDTH=8.
module tb_subtractor_four_bit_serial;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       in_valid = 1'b0, out_ready = 1'b0, bin = 1'b0;
  logic [3:0] a = '0, b = '0;
  logic       in_ready, out_valid, bout, busy;
  logic [3:0] diff;

  logic       in_valid8 = 1'b0, out_ready8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       in_ready8, out_valid8, bout8, busy8;
  logic [7:0] diff8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  subtractor_four_bit_serial #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .busy(busy)
  );

  subtractor_four_bit_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .bin(bin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .diff(diff8), .bout(bout8), .busy(busy8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full operation with out_ready low until the result is seen.
  task automatic do_op(input string tag, input logic [3:0] va, input logic [3:0] vb,
                       input logic vbin, input logic [3:0] ed, input logic eb);
    int n;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a = va; b = vb; bin = vbin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd5);
    chk({tag, "_diff"}, 32'(diff), 32'(ed));
    chk({tag, "_bout"}, 32'(bout), 32'(eb));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n, idx, done_cnt, last_hs, cyc, r;
    int expq[$];

    // Reset state
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic 9-3-0, per-cycle busy/out_valid profile
    chk("basic_in_ready", 32'(in_ready), 32'd1);
    a = 4'd9; b = 4'd3; bin = 1'b0; in_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      in_valid = 1'b0;
      chk($sformatf("basic_busy_c%0d", k), 32'(busy), 32'd1);
      chk($sformatf("basic_ov_c%0d", k), 32'(out_valid), (k == 5) ? 32'd1 : 32'd0);
    end
    chk("basic_diff", 32'(diff), 32'd6);
    chk("basic_bout", 32'(bout), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("basic_idle", 32'(in_ready), 32'd1);
    chk("basic_busy_c6", 32'(busy), 32'd0);

    // Underflow cases
    do_op("uf_3_9_0", 4'd3, 4'd9, 1'b0, 4'hA, 1'b1);
    do_op("uf_0_0_1", 4'd0, 4'd0, 1'b1, 4'hF, 1'b1);
    do_op("uf_15_15_1", 4'd15, 4'd15, 1'b1, 4'hF, 1'b1);

    // Backpressure: 5-2-0 held in DONE while new operands are offered
    a = 4'd5; b = 4'd2; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("bp_latency", 32'(n), 32'd5);
    a = 4'd7; b = 4'd1; bin = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_diff", 32'(diff), 32'd3);
      chk("bp_bout", 32'(bout), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    chk("bp_release_diff_held", 32'(diff), 32'd3);

    // Reset asserted in cycle 2 of an operation
    a = 4'd14; b = 4'd4; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_diff", 32'(diff), 32'd0);
    chk("mrst_bout", 32'(bout), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("mrst_no_ov", 32'(out_valid), 32'd0);
    end
    do_op("post_rst_12_5_0", 4'd12, 4'd5, 1'b0, 4'd7, 1'b0);

    // Exhaustive stream with out_ready held high
    out_ready = 1'b1;
    idx = 0; done_cnt = 0; last_hs = 0; cyc = 0;
    while (done_cnt < 512 && cyc < 6000) begin
      if (out_valid) begin
        chk("stream_result", 32'({bout, diff}), 32'(expq.pop_front()));
        done_cnt++;
      end
      if (idx < 512) begin
        a = idx[8:5]; b = idx[4:1]; bin = idx[0]; in_valid = 1'b1;
        if (in_ready) begin
          if (idx > 0) chk("stream_gap", 32'(cyc - last_hs), 32'd6);
          last_hs = cyc;
          r = int'(a) - int'(b) - int'(bin);
          expq.push_back(((r < 0) ? 16 : 0) | (r & 15));
          idx++;
        end
      end else begin
        in_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("stream_completed", 32'(done_cnt), 32'd512);

    // WIDTH=8: 0x10 - 0x01 - 1
    chk("w8_in_ready", 32'(in_ready8), 32'd1);
    a8 = 8'h10; b8 = 8'h01; bin8 = 1'b1; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    n = 1;
    while (!out_valid8 && n < 30) begin
      tick();
      n++;
    end
    chk("w8_latency", 32'(n), 32'd9);
    chk("w8_diff", 32'(diff8), 32'h0E);
    chk("w8_bout", 32'(bout8), 32'd0);
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    chk("w8_idle", 32'(in_ready8), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
